dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store initiator that sits between the RV32I execute stage and the data memory. Accepts one load or store request at a time over a valid/ready handshake and drives the data memory write-enable, write-mode, address and write-data ports. For loads it captures the memory's registered read word and returns a sign- or zero-extended result. It rejects misaligned, out-of-range and illegal-funct3 requests without touching memory.

## Interface
- `MEM_BYTES`, default 1024: memory size in bytes, used for the range check.
- `CHECK_ALIGN`, default 1: 1 = halfword and word accesses must be naturally aligned; 0 = no alignment check.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block idle and can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3 of the LOAD/STORE instruction.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, taken from rs2.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_rdata`  out  32: load result; 0 for stores and errors.
- `rsp_err`  out  1: qualified by `rsp_valid`; request was rejected.
- `dMemWE`  out  1: memory write enable.
- `dMemWMode`  out  3: memory write mode. 010 = word, 011 = byte only, 100 = halfword only.
- `dMemAddr`  out  32: memory byte address.
- `dMemDataIn`  out  32: memory write data.
- `dMemDataOut`  in  32: memory read word. The memory registers it on a clock edge while `dMemWE` = 0. Bytes are little-endian starting at `dMemAddr`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ERROR.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`, then classify the request.
  - A legal request goes to ISSUE; an illegal one goes to ERROR.
- A request is illegal if any of the following holds:
  - Load funct3 is not one of 000, 001, 010, 100, 101.
  - Store funct3 is not one of 000, 001, 010.
  - `CHECK_ALIGN` = 1 and either a halfword access has addr[0] = 1, or a word access has addr[1:0] != 0.
  - `addr + 3 >= MEM_BYTES`. This applies to all sizes, because the memory always touches 4 bytes on a read. Compute the sum at 33-bit width so that a wrap above 0xFFFFFFFF counts as out of range.
- ISSUE:
  - `dMemAddr` = latched address.
  - For a store: `dMemWE` = 1, `dMemDataIn` = latched wdata, and `dMemWMode` from funct3: SB 000 -> 011, SH 001 -> 100, SW 010 -> 010.
  - For a load: `dMemWE` = 0, so the memory registers the read word at the end of this cycle.
  - Always transitions to CAPTURE.
- CAPTURE:
  - `dMemWE` = 0 and `dMemAddr` is held.
  - For a load, compute the result from `dMemDataOut`:
    - LB: sign-extend [7:0].
    - LH: sign-extend [15:0].
    - LW: [31:0].
    - LBU: zero-extend [7:0].
    - LHU: zero-extend [15:0].
  - Register the result into `rsp_rdata`, set `rsp_valid` = 1 and `rsp_err` = 0 for the next cycle, and go to IDLE.
  - For a store: `rsp_rdata` = 0.
- ERROR: set `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0 for the next cycle, then go to IDLE. `dMemWE` is never asserted for a rejected request.
- `dMemWE` is 1 only in ISSUE with a store latched. `dMemWMode` = 010 whenever `dMemWE` = 0.

## Timing
- Reset values, applied asynchronously on `rst` = 0:
  - state = IDLE.
  - `req_ready` = 1.
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0.
  - `dMemWE` = 0, `dMemWMode` = 010, `dMemAddr` = 0, `dMemDataIn` = 0.
- Legal request accepted at edge N:
  - ISSUE during cycle N..N+1.
  - CAPTURE during cycle N+1..N+2.
  - `rsp_valid` high for exactly the cycle after edge N+2.
- Illegal request accepted at edge N: `rsp_valid` with `rsp_err` is high for exactly the cycle after edge N+1.
- `req_ready` = 0 from the accept edge until the state returns to IDLE. The response cycle is an IDLE cycle, so a new request may be accepted at that same edge (back-to-back, 3-cycle throughput).
- `req_*` inputs are ignored while `req_ready` = 0.
- Reset asserted mid-operation:
  - An in-flight store in ISSUE is abandoned: `dMemWE` drops immediately and asynchronously.
  - No `rsp_valid` is produced for the abandoned request.
- `rsp_valid` is never high for two consecutive cycles.

## Test plan
- **SW then LW:** SW addr 0x10, wdata 0xDEADBEEF -> `dMemWE` = 1 for exactly one cycle with mode 010, then `rsp_valid` with err = 0. LW 0x10 -> `rsp_rdata` = 0xDEADBEEF two edges after accept.
- **Sign and zero extension:** memory 0x20..0x23 = 0x80 0xFF 0x12 0x34.
  - LB 0x20 -> 0xFFFFFF80.
  - LBU 0x20 -> 0x00000080.
  - LH 0x20 -> 0xFFFFFF80.
  - LHU 0x20 -> 0x0000FF80.
  - LW 0x20 -> 0x3412FF80.
- **SB/SH byte masking:** word 0x11223344 at 0x30. SB 0x31 with data 0xAA -> mode 011. SH 0x32 with data 0xBBCC -> mode 100. LW 0x30 -> 0xBBCCAA44.
- **Error cases:** each of the following gives `rsp_err` = 1 one edge after accept, `rdata` = 0, and `dMemWE` never rises:
  - LH 0x41.
  - SW 0x42.
  - LW 0x3FD, with `MEM_BYTES` = 1024.
  - Load funct3 011.
  - LW 0xFFFFFFFE (wrap).
- **Back-to-back:** hold `req_valid` high for 4 loads -> 4 `rsp_valid` pulses spaced 3 cycles apart. `req_ready` is low for 2 cycles after each accept. No response is lost or duplicated.
- **Reset mid-store:** assert `rst` = 0 during ISSUE of an SW -> `dMemWE` falls without waiting for a clock edge and no `rsp_valid` appears. After release, `req_ready` = 1 and a new LW completes normally.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus data-memory port bundle for dmem_lsu.
// The slave modport is the LSU; the master modport is the execute stage plus the memory.
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        dMemWE;
   logic [2:0]  dMemWMode;
   logic [31:0] dMemAddr;
   logic [31:0] dMemDataIn;
   logic [31:0] dMemDataOut;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, dMemDataOut,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
             dMemWE, dMemWMode, dMemAddr, dMemDataIn
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, dMemDataOut,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
             dMemWE, dMemWMode, dMemAddr, dMemDataIn
   );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store initiator: one request at a time, issues to a memory with a
// registered read port, returns extended load data or an error pulse.
module dmem_lsu #(
   parameter int unsigned MEM_BYTES   = 1024,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input logic       clk,
   input logic       rst,
   dmem_lsu_if.slave bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_ERROR   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        accept, f3_ok, misalign, out_of_range, illegal;
   logic [31:0] load_val;

   assign accept = (state_q == S_IDLE) && bus.req_valid;

   always_comb begin
      if (bus.req_we) f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
      else            f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   end

   assign misalign = CHECK_ALIGN &&
                     (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
   // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap back into range
   assign out_of_range = ({1'b0, bus.req_addr} + 33'd3) >= 33'(MEM_BYTES);
   assign illegal      = !f3_ok || misalign || out_of_range;

   always_comb begin
      case (f3_q)
         3'b000:  load_val = {{24{bus.dMemDataOut[7]}}, bus.dMemDataOut[7:0]};
         3'b001:  load_val = {{16{bus.dMemDataOut[15]}}, bus.dMemDataOut[15:0]};
         3'b010:  load_val = bus.dMemDataOut;
         3'b100:  load_val = {24'd0, bus.dMemDataOut[7:0]};
         3'b101:  load_val = {16'd0, bus.dMemDataOut[15:0]};
         default: load_val = 32'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rdata_d     = 32'd0;
      case (state_q)
         S_IDLE:    if (accept) state_d = illegal ? S_ERROR : S_ISSUE;
         S_ISSUE:   state_d = S_CAPTURE;
         S_CAPTURE: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rdata_d     = we_q ? 32'd0 : load_val;
         end
         S_ERROR: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= 32'd0;
         we_q        <= 1'b0;
         f3_q        <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
         if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
      end
   end

   // write enable decodes straight from state so reset removes it without a clock
   assign bus.dMemWE     = (state_q == S_ISSUE) && we_q;
   assign bus.dMemWMode  = !bus.dMemWE            ? 3'b010 :
                           (f3_q[1:0] == 2'b00)   ? 3'b011 :
                           (f3_q[1:0] == 2'b01)   ? 3'b100 : 3'b010;
   assign bus.dMemAddr   = addr_q;
   assign bus.dMemDataIn = wdata_q;
   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.rsp_rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array memory model, directed scenarios, random
// requests checked against an arithmetic reference of the load/store rules.
module tb_dmem_lsu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ncmp = 0;
   int   nfail = 0;

   logic [7:0] mem [0:1023];
   logic [7:0] ref_mem [0:1023];

   dmem_lsu_if bus ();

   dmem_lsu #(.MEM_BYTES(1024), .CHECK_ALIGN(1'b1)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // memory: registered read while WE=0, byte-masked write while WE=1
   always @(posedge clk) begin
      automatic int a = int'(bus.dMemAddr[9:0]);
      if (bus.dMemWE) begin
         case (bus.dMemWMode)
            3'b011: mem[a] <= bus.dMemDataIn[7:0];
            3'b100: begin
               mem[a] <= bus.dMemDataIn[7:0]; mem[(a+1)%1024] <= bus.dMemDataIn[15:8];
            end
            default: for (int i = 0; i < 4; i++) mem[(a+i)%1024] <= bus.dMemDataIn[8*i +: 8];
         endcase
      end else begin
         bus.dMemDataOut <= {mem[(a+3)%1024], mem[(a+2)%1024], mem[(a+1)%1024], mem[a]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit ref_illegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
      bit bad_f3;
      bad_f3 = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (bad_f3) return 1'b1;
      if ((longint'(a) % acc_size(f3)) != 0) return 1'b1;
      return (longint'(a) + 3) >= 1024;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      longint v = 0;
      int n = acc_size(f3);
      for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      return 32'(v);
   endfunction

   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got);
      bit exp_err;
      logic [31:0] exp_data;
      logic [2:0] exp_mode;
      int t = 0, we_cnt = 0, rsp_cnt = 0, rsp_k = -1;
      logic err_seen = 1'b0;
      got = 32'hx;
      exp_err  = ref_illegal(we, f3, a);
      exp_data = (we || exp_err) ? 32'd0 : ref_load(f3, a);
      exp_mode = (acc_size(f3) == 1) ? 3'b011 : (acc_size(f3) == 2) ? 3'b100 : 3'b010;
      @(negedge clk);
      while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
      chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = a; bus.req_wdata = wd;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.req_valid = 1'b0;
            chk("ready_low_after_accept", {31'd0, bus.req_ready}, 32'd0);
            if (!exp_err) chk("issue_addr", bus.dMemAddr, a);
            if (!exp_err && we) chk("issue_wdata", bus.dMemDataIn, wd);
         end
         if (bus.dMemWE) begin
            we_cnt++;
            chk("wmode", {29'd0, bus.dMemWMode}, {29'd0, exp_mode});
         end else if (k <= 2) begin
            chk("wmode_idle", {29'd0, bus.dMemWMode}, 32'd2);
         end
         if (bus.rsp_valid) begin
            rsp_cnt++;
            if (rsp_k < 0) begin rsp_k = k; got = bus.rsp_rdata; err_seen = bus.rsp_err; end
         end
      end
      chk("rsp_count", rsp_cnt, 32'd1);
      chk("rsp_latency", rsp_k, exp_err ? 32'd1 : 32'd2);
      chk("rsp_err", {31'd0, err_seen}, {31'd0, exp_err});
      chk("rsp_rdata", got, exp_data);
      chk("we_cycles", we_cnt, (we && !exp_err) ? 32'd1 : 32'd0);
      if (we && !exp_err)
         for (int i = 0; i < acc_size(f3); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [31:0] qexp [$];
      int last_rsp, ready_low, nrsp, idx;
      bit acc_pending;
      logic [31:0] baddr [4];

      for (int i = 0; i < 1024; i++) begin
         mem[i] = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

      // reset state
      #12;
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_we", {31'd0, bus.dMemWE}, 32'd0);
      chk("rst_wmode", {29'd0, bus.dMemWMode}, 32'd2);
      chk("rst_addr", bus.dMemAddr, 32'd0);
      chk("rst_datain", bus.dMemDataIn, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // SW then LW
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
      chk("lw_deadbeef", r, 32'hDEADBEEF);

      // sign / zero extension
      do_req(1'b1, 3'b010, 32'h20, 32'h3412FF80, r);
      do_req(1'b0, 3'b000, 32'h20, 32'h0, r); chk("lb", r, 32'hFFFFFF80);
      do_req(1'b0, 3'b100, 32'h20, 32'h0, r); chk("lbu", r, 32'h00000080);
      do_req(1'b0, 3'b001, 32'h20, 32'h0, r); chk("lh", r, 32'hFFFFFF80);
      do_req(1'b0, 3'b101, 32'h20, 32'h0, r); chk("lhu", r, 32'h0000FF80);
      do_req(1'b0, 3'b010, 32'h20, 32'h0, r); chk("lw", r, 32'h3412FF80);

      // SB / SH byte masking
      do_req(1'b1, 3'b010, 32'h30, 32'h11223344, r);
      do_req(1'b1, 3'b000, 32'h31, 32'h000000AA, r);
      do_req(1'b1, 3'b001, 32'h32, 32'h0000BBCC, r);
      do_req(1'b0, 3'b010, 32'h30, 32'h0, r); chk("sb_sh_merge", r, 32'hBBCCAA44);

      // error cases
      do_req(1'b0, 3'b001, 32'h41, 32'h0, r);
      do_req(1'b1, 3'b010, 32'h42, 32'h55555555, r);
      do_req(1'b0, 3'b010, 32'h3FD, 32'h0, r);
      do_req(1'b0, 3'b011, 32'h40, 32'h0, r);
      do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, r);
      do_req(1'b0, 3'b010, 32'h3FC, 32'h0, r);

      // randomized requests
      for (int n = 0; n < 60; n++) begin
         bit w;
         logic [2:0] f;
         logic [31:0] a;
         int sel;
         w = 1'($urandom);
         f = 3'($urandom);
         sel = $urandom_range(0, 9);
         a = (sel == 0) ? $urandom : 32'($urandom_range(0, 1023));
         if (sel > 3) a = a & ~32'(acc_size(f) - 1);
         do_req(w, f, a, $urandom, r);
      end

      // back-to-back loads with req_valid held high
      for (int i = 0; i < 4; i++) baddr[i] = 32'(($urandom_range(0, 254)) * 4);
      @(negedge clk);
      idx = 0; acc_pending = 1'b0; last_rsp = -1; ready_low = 0; nrsp = 0;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = baddr[0];
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (acc_pending) begin
            idx++;
            if (idx < 4) bus.req_addr = baddr[idx];
            else bus.req_valid = 1'b0;
         end
         acc_pending = bus.req_ready && bus.req_valid;
         if (acc_pending) qexp.push_back(ref_load(3'b010, bus.req_addr));
         if (!bus.req_ready) ready_low++;
         if (bus.rsp_valid) begin
            nrsp++;
            if (last_rsp >= 0) chk("b2b_spacing", cyc - last_rsp, 32'd3);
            last_rsp = cyc;
            if (qexp.size() > 0) chk("b2b_rdata", bus.rsp_rdata, qexp.pop_front());
            chk("b2b_err", {31'd0, bus.rsp_err}, 32'd0);
         end
         @(negedge clk);
      end
      chk("b2b_rsp_count", nrsp, 32'd4);
      chk("b2b_ready_low", ready_low, 32'd8);

      // reset during the ISSUE cycle of a store
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h50; bus.req_wdata = 32'h12345678;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("midrst_we_before", {31'd0, bus.dMemWE}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_we_async_drop", {31'd0, bus.dMemWE}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      end
      rst_n = 1'b1;
      chk("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("postrst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      end
      do_req(1'b0, 3'b010, 32'h50, 32'h0, r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
